// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types, mode constants and range helpers for the processing element
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WS       = 2'd1,
    OS_ACC   = 2'd2,
    OS_DRAIN = 2'd3
  } pe_state_t;

  localparam logic PE_MODE_WS = 1'b0;
  localparam logic PE_MODE_OS = 1'b1;

  // True when v is representable as a signed w-bit value.
  function automatic logic fits(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (v >= lo) && (v <= hi);
  endfunction

  // Clamp v into the signed w-bit range.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Keep the low w bits of v and sign-extend them (two's-complement wrap).
  function automatic logic signed [63:0] wrap(input logic signed [63:0] v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

endpackage

// File: rtl/pe_fxp_mac.sv
// rtl/pe_fxp_mac.sv - combinational fixed-point multiply-add with overflow detect (PE_SAT_EN selects saturation)
module pe_fxp_mac
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] w,
  input  logic [DATA_WIDTH-1:0] addend,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  ovf
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0] full;
  logic signed [PW-1:0] shifted;
  logic signed [63:0]   prod_wide;
  logic signed [63:0]   prod_red;
  logic signed [63:0]   sum_wide;
  logic signed [63:0]   sum_red;

  // Full-width product, then floor-shift back to the fixed-point scale.
  assign full      = PW'(signed'(a)) * PW'(signed'(w));
  assign shifted   = full >>> FRAC_BITS;
  assign prod_wide = 64'(shifted);

`ifdef PE_SAT_EN
  assign prod_red = sat(prod_wide, DATA_WIDTH);
`else
  assign prod_red = wrap(prod_wide, DATA_WIDTH);
`endif

  // The add sees the already-reduced product, so each stage is judged on its own.
  assign sum_wide = prod_red + 64'(signed'(addend));

`ifdef PE_SAT_EN
  assign sum_red = sat(sum_wide, DATA_WIDTH);
`else
  assign sum_red = wrap(sum_wide, DATA_WIDTH);
`endif

  assign result = DATA_WIDTH'(sum_red);
  assign ovf    = !fits(prod_wide, DATA_WIDTH) || !fits(sum_wide, DATA_WIDTH);

endmodule

// File: rtl/pe_gen.sv
// rtl/pe_gen.sv - dual-mode (WS/OS) systolic processing element; define PE_SAT_EN for saturating arithmetic
module pe_gen
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pe_enabled,
  input  logic                  pe_mode,
  input  logic [DATA_WIDTH-1:0] pe_psum_in,
  input  logic                  pe_psum_valid_in,
  input  logic [DATA_WIDTH-1:0] pe_weight_in,
  input  logic                  pe_accept_w_in,
  input  logic [DATA_WIDTH-1:0] pe_input_in,
  input  logic                  pe_valid_in,
  input  logic                  pe_switch_in,
  input  logic                  pe_drain_in,
  output logic [DATA_WIDTH-1:0] pe_psum_out,
  output logic                  pe_psum_valid_out,
  output logic [DATA_WIDTH-1:0] pe_weight_out,
  output logic                  pe_accept_w_out,
  output logic [DATA_WIDTH-1:0] pe_input_out,
  output logic                  pe_valid_out,
  output logic                  pe_switch_out,
  output logic                  pe_drain_out,
  output logic                  pe_ovf_out
);

  pe_state_t state;
  pe_state_t state_next;

  logic [DATA_WIDTH-1:0] w_active;
  logic [DATA_WIDTH-1:0] w_inactive;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] mac_w;
  logic [DATA_WIDTH-1:0] mac_addend;
  logic [DATA_WIDTH-1:0] mac_result;
  logic                  mac_ovf;
  logic                  os_mac;

  assign os_mac = pe_valid_in && pe_accept_w_in;

  // Select MAC operands: WS uses the effective weight plus psum_in; OS accumulates,
  // restarting from zero when the accumulator is being drained this cycle.
  always_comb begin
    mac_w      = pe_weight_in;
    mac_addend = '0;
    if (state == WS) begin
      mac_w      = pe_switch_in ? w_inactive : w_active;
      mac_addend = pe_psum_in;
    end else if (!pe_drain_in) begin
      mac_addend = acc;
    end
  end

  pe_fxp_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .a     (pe_input_in),
    .w     (mac_w),
    .addend(mac_addend),
    .result(mac_result),
    .ovf   (mac_ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; disabling always returns to IDLE where the mode is recaptured.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     state_next = (pe_mode == PE_MODE_OS) ? OS_ACC : WS;
      WS:       state_next = WS;
      OS_ACC:   if (pe_drain_in) state_next = OS_DRAIN;
      OS_DRAIN: begin
        if (pe_drain_in)            state_next = OS_DRAIN;
        else if (!pe_psum_valid_in) state_next = OS_ACC;
      end
      default:  state_next = IDLE;
    endcase
    if (!pe_enabled) state_next = IDLE;
  end

  // Datapath: forwarding registers, weights, accumulator, psum output and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n || !pe_enabled || state == IDLE) begin
      pe_psum_out       <= '0;
      pe_psum_valid_out <= 1'b0;
      pe_weight_out     <= '0;
      pe_accept_w_out   <= 1'b0;
      pe_input_out      <= '0;
      pe_valid_out      <= 1'b0;
      pe_switch_out     <= 1'b0;
      pe_drain_out      <= 1'b0;
      pe_ovf_out        <= 1'b0;
      w_active          <= '0;
      w_inactive        <= '0;
      acc               <= '0;
    end else begin
      pe_input_out      <= pe_valid_in ? pe_input_in : '0;
      pe_valid_out      <= pe_valid_in;
      pe_weight_out     <= pe_accept_w_in ? pe_weight_in : '0;
      pe_accept_w_out   <= pe_accept_w_in;
      pe_switch_out     <= pe_switch_in;
      pe_drain_out      <= pe_drain_in;
      pe_psum_out       <= '0;
      pe_psum_valid_out <= 1'b0;
      case (state)
        WS: begin
          if (pe_switch_in)   w_active   <= w_inactive;
          if (pe_accept_w_in) w_inactive <= pe_weight_in;
          if (pe_valid_in) begin
            pe_psum_out       <= mac_result;
            pe_psum_valid_out <= 1'b1;
            if (mac_ovf) pe_ovf_out <= 1'b1;
          end
        end
        OS_ACC, OS_DRAIN: begin
          if (os_mac && mac_ovf) pe_ovf_out <= 1'b1;
          if (pe_drain_in) begin
            pe_psum_out       <= acc;
            pe_psum_valid_out <= 1'b1;
            acc               <= os_mac ? mac_result : '0;
          end else begin
            if (os_mac) acc <= mac_result;
            if (state == OS_DRAIN && pe_psum_valid_in) begin
              pe_psum_out       <= pe_psum_in;
              pe_psum_valid_out <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_gen.sv
// tb/tb_pe_gen.sv - scoreboard bench for pe_gen with directed cases and randomized traffic
module tb_pe_gen;

  localparam longint MAXV = 32767;
  localparam longint MINV = -32768;
  localparam int     FB   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pe_enabled = 1'b0;
  logic        pe_mode = 1'b0;
  logic [15:0] pe_psum_in = '0;
  logic        pe_psum_valid_in = 1'b0;
  logic [15:0] pe_weight_in = '0;
  logic        pe_accept_w_in = 1'b0;
  logic [15:0] pe_input_in = '0;
  logic        pe_valid_in = 1'b0;
  logic        pe_switch_in = 1'b0;
  logic        pe_drain_in = 1'b0;
  logic [15:0] pe_psum_out;
  logic        pe_psum_valid_out;
  logic [15:0] pe_weight_out;
  logic        pe_accept_w_out;
  logic [15:0] pe_input_out;
  logic        pe_valid_out;
  logic        pe_switch_out;
  logic        pe_drain_out;
  logic        pe_ovf_out;

  pe_gen #(.DATA_WIDTH(16), .FRAC_BITS(FB)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pe_enabled       (pe_enabled),
    .pe_mode          (pe_mode),
    .pe_psum_in       (pe_psum_in),
    .pe_psum_valid_in (pe_psum_valid_in),
    .pe_weight_in     (pe_weight_in),
    .pe_accept_w_in   (pe_accept_w_in),
    .pe_input_in      (pe_input_in),
    .pe_valid_in      (pe_valid_in),
    .pe_switch_in     (pe_switch_in),
    .pe_drain_in      (pe_drain_in),
    .pe_psum_out      (pe_psum_out),
    .pe_psum_valid_out(pe_psum_valid_out),
    .pe_weight_out    (pe_weight_out),
    .pe_accept_w_out  (pe_accept_w_out),
    .pe_input_out     (pe_input_out),
    .pe_valid_out     (pe_valid_out),
    .pe_switch_out    (pe_switch_out),
    .pe_drain_out     (pe_drain_out),
    .pe_ovf_out       (pe_ovf_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] psum;
    logic        pv;
    logic [15:0] w;
    logic        aw;
    logic [15:0] in;
    logic        v;
    logic        sw;
    logic        dr;
    logic        ovf;
  } out_t;

  typedef struct {
    out_t  o;
    string tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: 0 idle, 1 weight-stationary, 2 accumulate, 3 draining.
  int     m_st  = 0;
  longint m_acc = 0;
  longint m_wi  = 0;
  longint m_wa  = 0;
  bit     m_ovf = 0;

  function automatic longint to_s(input logic [15:0] x);
    return longint'(signed'(x));
  endfunction

  function automatic longint mulfx(input longint a, input longint w);
    return (a * w) >>> FB;
  endfunction

  // Bring x into 16-bit signed range, flagging any out-of-range value.
  function automatic longint fit(input longint x, inout bit o);
    longint m;
    if (x <= MAXV && x >= MINV) return x;
    o = 1'b1;
`ifdef PE_SAT_EN
    return (x > MAXV) ? MAXV : MINV;
`else
    m = x & 64'hFFFF;
    if (m >= 32768) m = m - 65536;
    return m;
`endif
  endfunction

  task automatic model_step(output out_t e);
    bit     o;
    bit     mac_q;
    longint p;
    longint s;
    longint weff;
    e = '0;
    o = 1'b0;
    if (!rst_n || !pe_enabled) begin
      m_st = 0; m_acc = 0; m_wi = 0; m_wa = 0; m_ovf = 0;
    end else if (m_st == 0) begin
      m_st = pe_mode ? 2 : 1;
    end else begin
      e.w  = pe_accept_w_in ? pe_weight_in : 16'h0;
      e.aw = pe_accept_w_in;
      e.in = pe_valid_in ? pe_input_in : 16'h0;
      e.v  = pe_valid_in;
      e.sw = pe_switch_in;
      e.dr = pe_drain_in;
      if (m_st == 1) begin
        weff = pe_switch_in ? m_wi : m_wa;
        if (pe_valid_in) begin
          p = fit(mulfx(to_s(pe_input_in), weff), o);
          s = fit(p + to_s(pe_psum_in), o);
          e.psum = 16'(s);
          e.pv   = 1'b1;
        end
        if (pe_switch_in)   m_wa = m_wi;
        if (pe_accept_w_in) m_wi = to_s(pe_weight_in);
      end else begin
        mac_q = pe_valid_in && pe_accept_w_in;
        p = mac_q ? fit(mulfx(to_s(pe_input_in), to_s(pe_weight_in)), o) : 0;
        if (pe_drain_in) begin
          e.psum = 16'(m_acc);
          e.pv   = 1'b1;
          m_acc  = p;
          m_st   = 3;
        end else begin
          if (mac_q) m_acc = fit(m_acc + p, o);
          if (m_st == 3) begin
            if (pe_psum_valid_in) begin
              e.psum = pe_psum_in;
              e.pv   = 1'b1;
            end else begin
              m_st = 2;
            end
          end
        end
      end
      if (o) m_ovf = 1'b1;
      e.ovf = m_ovf;
    end
  endtask

  task automatic cyc(input string tag, input logic r, input logic en, input logic md,
                     input logic [15:0] psi, input logic pvi, input logic [15:0] wi,
                     input logic awi, input logic [15:0] ii, input logic vi,
                     input logic swi, input logic dri);
    out_t e;
    exp_t x;
    @(negedge clk);
    rst_n = r; pe_enabled = en; pe_mode = md;
    pe_psum_in = psi; pe_psum_valid_in = pvi;
    pe_weight_in = wi; pe_accept_w_in = awi;
    pe_input_in = ii; pe_valid_in = vi;
    pe_switch_in = swi; pe_drain_in = dri;
    model_step(e);
    x.o = e;
    x.tag = tag;
    q.push_back(x);
  endtask

  // Monitor: one response per clock, compared against the oldest expectation.
  initial begin
    exp_t x;
    out_t got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        got = '{pe_psum_out, pe_psum_valid_out, pe_weight_out, pe_accept_w_out,
                pe_input_out, pe_valid_out, pe_switch_out, pe_drain_out, pe_ovf_out};
        checks++;
        if (got !== x.o) begin
          errors++;
          $display("FAIL %s: got psum=%h pv=%b w=%h aw=%b in=%h v=%b sw=%b dr=%b ovf=%b; want psum=%h pv=%b w=%h aw=%b in=%h v=%b sw=%b dr=%b ovf=%b",
                   x.tag, got.psum, got.pv, got.w, got.aw, got.in, got.v, got.sw, got.dr, got.ovf,
                   x.o.psum, x.o.pv, x.o.w, x.o.aw, x.o.in, x.o.v, x.o.sw, x.o.dr, x.o.ovf);
        end
      end
    end
  end

  initial begin
    // Reset state
    cyc("reset0", 0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0, 0);
    cyc("reset1", 0, 1, 0, 16'h1234, 1, 16'h5678, 1, 16'h9abc, 1, 1, 1);
    // WS: idle entry cycle ignores inputs, then load, switch, MAC
    cyc("ws_idle",   1, 1, 0, 16'h1111, 1, 16'h2222, 1, 16'h3333, 1, 1, 0);
    cyc("ws_load",   1, 1, 0, 16'h0000, 0, 16'h0200, 1, 16'h0000, 0, 0, 0);
    cyc("ws_switch", 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 1, 0);
    cyc("ws_mac",    1, 1, 0, 16'h0100, 0, 16'h0000, 0, 16'h0180, 1, 0, 0);
    // WS bypass: switch with MAC in the same cycle uses the inactive weight
    cyc("ws_load2",  1, 1, 0, 16'h0000, 0, 16'h0100, 1, 16'h0000, 0, 0, 0);
    cyc("ws_bypass", 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0300, 1, 1, 0);
    // WS overflow
    cyc("ovf_load",  1, 1, 0, 16'h0000, 0, 16'h0200, 1, 16'h0000, 0, 0, 0);
    cyc("ovf_mac",   1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h7F00, 1, 1, 0);
    cyc("ovf_hold",  1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    // Disable clears overflow, then enter OS
    cyc("dis_clear", 1, 0, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    cyc("os_idle",   1, 1, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    cyc("os_mac1",   1, 1, 1, 16'h0000, 0, 16'h0200, 1, 16'h0100, 1, 0, 0);
    cyc("os_half",   1, 1, 1, 16'h0000, 0, 16'h0700, 1, 16'h0000, 0, 0, 0);
    cyc("os_mac2",   1, 1, 1, 16'h0000, 0, 16'h0200, 1, 16'h0080, 1, 0, 0);
    cyc("os_mac3",   1, 1, 1, 16'h0000, 0, 16'h0100, 1, 16'hFF00, 1, 0, 0);
    // Column drain as the bottom row: own acc, then two upstream psums, then valid drops
    cyc("drain_own", 1, 1, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    cyc("col_row1",  1, 1, 1, 16'h1111, 1, 16'h0000, 0, 16'h0000, 0, 0, 0);
    cyc("col_row0",  1, 1, 1, 16'h2222, 1, 16'h0000, 0, 16'h0000, 0, 0, 0);
    cyc("col_end",   1, 1, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    cyc("acc_accst", 1, 1, 1, 16'h4444, 1, 16'h0000, 0, 16'h0000, 0, 0, 0);
    cyc("acc_reset", 1, 1, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    cyc("drain_end", 1, 1, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    // Reset mid-drain
    cyc("md_mac",    1, 1, 1, 16'h0000, 0, 16'h0100, 1, 16'h0100, 1, 0, 0);
    cyc("md_drain",  1, 1, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    cyc("md_rst",    0, 1, 1, 16'h3333, 1, 16'h0000, 0, 16'h0000, 0, 0, 0);
    cyc("md_after",  1, 1, 1, 16'h3333, 1, 16'h0000, 0, 16'h0000, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc("random",
          ($urandom_range(0, 299) != 0), ($urandom_range(0, 79) != 0), 1'($urandom_range(0, 1)),
          16'($urandom), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 1023)),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 1023)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
    end
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_gen.md
# pe_gen

Parametrised, dual-mode processing element for the systolic array. Each instance supports either a weight-stationary (WS) or an output-stationary (OS) dataflow. It performs signed fixed-point multiply-accumulate with configurable width and fraction bits. It forwards operands east and south, and in OS mode drains its local accumulator down the column.

## Interface
- DATA_WIDTH, 16, operand/psum/accumulator width (signed)
- FRAC_BITS, 8, fractional bits of the fixed-point format; 0 ≤ FRAC_BITS < DATA_WIDTH
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- pe_enabled  in  1  0 = synchronous clear to IDLE (same effect as reset, except mode capture)
- pe_mode  in  1  0 = WS, 1 = OS; captured only while in IDLE
- pe_psum_in  in  DATA_WIDTH  psum from north
- pe_psum_valid_in  in  1  psum_in qualifier (used in OS drain)
- pe_weight_in  in  DATA_WIDTH  weight from north
- pe_accept_w_in  in  1  weight_in qualifier
- pe_input_in  in  DATA_WIDTH  activation from west
- pe_valid_in  in  1  input_in qualifier
- pe_switch_in  in  1  WS: promote inactive weight to active
- pe_drain_in  in  1  OS: emit accumulator
- pe_psum_out  out  DATA_WIDTH  psum to south
- pe_psum_valid_out  out  1  psum_out qualifier
- pe_weight_out, pe_accept_w_out  out  DATA_WIDTH, 1  weight forward south
- pe_input_out, pe_valid_out, pe_switch_out, pe_drain_out  out  DATA_WIDTH, 1, 1, 1  forward east
- pe_ovf_out  out  1  sticky arithmetic overflow flag

## Operation
- FSM states: IDLE, WS, OS_ACC, OS_DRAIN. Reset or pe_enabled=0 → IDLE.
- IDLE → WS (pe_mode=0) or OS_ACC (pe_mode=1) at the first edge with pe_enabled=1. Inputs in that cycle are ignored.
- Arithmetic:
  - prod = (a × w) >>> FRAC_BITS, using the full 2·DATA_WIDTH product and an arithmetic shift (floor).
  - prod and the subsequent add are each reduced to DATA_WIDTH per the Configuration section.
  - Any out-of-range event sets pe_ovf_out. The flag clears only in IDLE.
- Forwarding, every non-IDLE cycle:
  - input_out/valid_out ← input_in/valid_in. When valid_in=0, input_out ← 0.
  - switch_out ← switch_in, drain_out ← drain_in.
  - weight_out/accept_w_out ← weight_in/accept_w_in. When accept_w_in=0, weight_out ← 0.
- WS:
  - accept_w_in loads w_inactive.
  - switch_in loads w_active ← w_inactive. The MAC of the same cycle uses w_inactive (bypass).
  - accept_w_in and switch_in together: the old w_inactive is promoted, and the new weight lands in w_inactive.
  - valid_in=1 → psum_out ← prod(input_in, w_eff) + psum_in, psum_valid_out ← 1. Otherwise psum_out ← 0, psum_valid_out ← 0.
- OS_ACC:
  - Operands are input_in and weight_in.
  - valid_in & accept_w_in → acc ← acc + prod. A cycle with only one of the two qualifiers is ignored.
  - drain_in → psum_out ← acc, psum_valid_out ← 1, acc ← prod if a MAC is qualified that cycle, else 0. State → OS_DRAIN.
- OS_DRAIN:
  - psum_valid_in=1 → psum_out ← psum_in, psum_valid_out ← 1.
  - psum_valid_in=0 → psum_out ← 0, psum_valid_out ← 0, state → OS_ACC.
  - MACs continue into acc during drain.
  - drain_in again emits the own acc and restarts the drain. A coincident psum_in is dropped; this is a protocol violation.
- Column drain sequence: with drain applied to all rows in cycle D, row r emits its own acc at D+1 and rows r-1…0 on the following cycles.

## Timing
- All outputs reset to 0 one edge after rst_n=0 or pe_enabled=0; acc, weights and ovf also clear.
- Latency: every forward path and the psum path is 1 cycle. No combinational input→output paths.
- Mode change requires passing through IDLE (pe_enabled low for ≥1 cycle).
- Reset mid-drain: the drain is aborted and in-flight psums are lost.

## Configuration
- PE_SAT_EN defined: prod and sum saturate to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- PE_SAT_EN undefined: two's-complement wrap.
- pe_ovf_out is set in both builds.

## Structure
- pe_pkg:
  - pe_state_t enum (IDLE, WS, OS_ACC, OS_DRAIN)
  - PE_MODE_WS/PE_MODE_OS constants
  - sat/wrap helper functions parametrised by width
- Sub-module pe_fxp_mac: combinational prod+add with overflow output. Used once for WS and once for OS accumulation; alternatively a single instance with muxed addend.

## Test plan
- WS, Q8.8: load w=0x0200, switch; input 0x0180, psum_in 0x0100 → psum_out 0x0400, valid, 1 cycle later.
- WS bypass: switch and valid in the same cycle with w_inactive=0x0100, input 0x0300, psum 0 → psum_out 0x0300. Previous active weight unused.
- OS: three qualified MACs (0x0100×0x0200, 0x0080×0x0200, 0xFF00×0x0100) then drain → psum_out 0x0200 once; acc restarts at 0.
- OS column drain (3 rows, simultaneous drain): bottom row emits own, row1, row0 values on consecutive cycles, then valid drops and the PE returns to OS_ACC.
- Overflow, WS: input 0x7F00 × w 0x0200 → 0x7FFF and ovf=1 with PE_SAT_EN; wrapped value 0xFE00 and ovf=1 without.
- rst_n low mid-drain → next edge all outputs 0, state IDLE; pe_enabled low clears ovf.
